// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I fetch stage.
// Branch funct3 encodings, FSM state enum, XLEN.
package fetch_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_VALID,
    S_HALT
  } state_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch bus: imem request/ready handshake and
// instruction valid/ready handshake to the consumer.
interface fetch_unit_if;
  import fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] pc;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata,
    output instr_valid,
    input  instr_ready,
    output instr,
    output pc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  pc
  );

endinterface

// File: rtl/branch_cmp.sv
// B-type condition evaluator (combinational).
// Unused funct3 codes (010/011) never take.
module branch_cmp
  import fetch_pkg::*;
(
  input  logic [2:0]      br_funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            cond_true
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (rs1_val == rs2_val);
  assign lt_s = ($signed(rs1_val) < $signed(rs2_val));
  assign lt_u = (rs1_val < rs2_val);

  always_comb begin
    cond_true = 1'b0;
    unique case (1'b1)
      (br_funct3 == F3_BEQ):  cond_true = eq;
      (br_funct3 == F3_BNE):  cond_true = !eq;
      (br_funct3 == F3_BLT):  cond_true = lt_s;
      (br_funct3 == F3_BGE):  cond_true = !lt_s;
      (br_funct3 == F3_BLTU): cond_true = lt_u;
      (br_funct3 == F3_BGEU): cond_true = !lt_u;
      default:                cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch / next-PC stage. Optional trap on misaligned
// targets is enabled by FETCH_MISALIGN_TRAP_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  fetch_unit_if.master     bus,
  input  logic             branch,
  input  logic [2:0]       br_funct3,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic [XLEN-1:0]  br_target,
  input  logic             jump,
  input  logic [XLEN-1:0]  jump_target,
  output logic             branch_taken,
  output logic [XLEN-1:0]  pc_next,
  output logic             misaligned
);

  state_e          state_q;
  state_e          state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] instr_d;
  logic [XLEN-1:0] pc_raw;
  logic            cond_true;
  logic            req;
  logic            vld;
  logic            accept;
  logic            trap;

  branch_cmp u_cmp (
    .br_funct3 (br_funct3),
    .rs1_val   (rs1_val),
    .rs2_val   (rs2_val),
    .cond_true (cond_true)
  );

  assign branch_taken = branch && cond_true;
  assign accept       = vld && bus.instr_ready;

  always_comb begin
    pc_raw = pc_q + 32'd4;
    if (jump)
      pc_raw = jump_target & ~32'd1;
    else if (branch_taken)
      pc_raw = br_target;
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned_q;
  logic misaligned_d;

  assign pc_next = pc_raw;
  assign trap    = accept && (pc_raw[1:0] != 2'b00);

  always_comb begin
    misaligned_d = misaligned_q;
    if (trap)
      misaligned_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      misaligned_q <= 1'b0;
    else
      misaligned_q <= misaligned_d;
  end

  assign misaligned = misaligned_q;
`else
  assign pc_next    = pc_raw & ~32'd3;
  assign trap       = 1'b0;
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (bus.imem_ready) state_d = S_VALID;
      S_VALID: if (bus.instr_ready)
                 state_d = trap ? S_HALT : S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req = 1'b0;
    vld = 1'b0;
    unique case (state_q)
      S_FETCH: req = 1'b1;
      S_VALID: vld = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    if (req && bus.imem_ready)
      instr_d = bus.imem_rdata;
    if (accept && !trap)
      pc_d = pc_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_VECTOR;
      instr_q <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = vld;
  assign bus.instr       = instr_q;
  assign bus.pc          = pc_q;

endmodule
